// File: rtl/sprite_render_if.sv
// sprite_render_if: scan position, control, ROM and pixel-output signals of the sprite renderer.
// The DUT side uses the slave modport; the video/ROM side uses the master modport.
interface sprite_render_if;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        video_on;
    logic        frame_tick;
    logic        move_en;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data;
    logic [7:0]  rgb;
    logic        pix_valid;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;

    modport slave (
        input  hcount, vcount, video_on, frame_tick, move_en, rom_data,
        output rom_addr, rgb, pix_valid, pos_x, pos_y
    );

    modport master (
        output hcount, vcount, video_on, frame_tick, move_en, rom_data,
        input  rom_addr, rgb, pix_valid, pos_x, pos_y
    );
endinterface

// File: rtl/sprite_render.sv
// sprite_render: two-stage sprite pixel pipeline over a 16x32 row ROM plus a bouncing position.
// Define SPRITE_MIRROR_EN to add the `mirror` input, which flips the sprite horizontally.
module sprite_render #(
    parameter int unsigned SPR_W    = 32,
    parameter int unsigned SPR_H    = 16,
    parameter int unsigned H_ACT    = 640,
    parameter int unsigned V_ACT    = 480,
    parameter int unsigned STEP     = 1,
    parameter logic [7:0]  FG_COLOR = 8'hFF,
    parameter logic [7:0]  BG_COLOR = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
`ifdef SPRITE_MIRROR_EN
    input  logic            mirror,
`endif
    sprite_render_if.slave  bus
);
    typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_e;

    typedef struct packed {
        dir_e       dir;
        logic [9:0] pos;
    } axis_t;

    localparam logic [10:0] SPR_W11 = 11'(SPR_W);
    localparam logic [10:0] SPR_H11 = 11'(SPR_H);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] X_MAX   = 11'(H_ACT - SPR_W);
    localparam logic [10:0] Y_MAX   = 11'(V_ACT - SPR_H);
    localparam logic [4:0]  COL_MAX = 5'(SPR_W - 1);

    // One bounce step on a single axis; the edge is clamped and the direction reverses there.
    function automatic axis_t axis_next(input logic [9:0] pos, input dir_e dir,
                                        input logic [10:0] lim);
        axis_t      nxt;
        logic [10:0] pos11;
        pos11    = {1'b0, pos};
        nxt.pos  = pos;
        nxt.dir  = dir;
        case (dir)
            DIR_INC: begin
                if ((pos11 + STEP11) > lim) begin
                    nxt.pos = lim[9:0];
                    nxt.dir = DIR_DEC;
                end else begin
                    nxt.pos = 10'(pos11 + STEP11);
                    nxt.dir = DIR_INC;
                end
            end
            DIR_DEC: begin
                if (pos11 < STEP11) begin
                    nxt.pos = 10'd0;
                    nxt.dir = DIR_INC;
                end else begin
                    nxt.pos = 10'(pos11 - STEP11);
                    nxt.dir = DIR_DEC;
                end
            end
            default: begin
                nxt.pos = 10'd0;
                nxt.dir = DIR_INC;
            end
        endcase
        return nxt;
    endfunction

    // Stage 1 registers
    logic [3:0] rom_addr_q, rom_addr_d;
    logic       hit_q;
    logic [4:0] col_q;
    logic       von_q;
    // Stage 2 registers
    logic [7:0] rgb_q, rgb_d;
    logic       pix_valid_q;
    // Sprite position and direction
    logic [9:0] pos_x_q, pos_x_d;
    logic [9:0] pos_y_q, pos_y_d;
    dir_e       dir_x_q, dir_x_d;
    dir_e       dir_y_q, dir_y_d;

    logic [10:0] hc_s, vc_s, px_s, py_s;
    logic        hit_s;
    logic [3:0]  row_s;
    logic [4:0]  col_s;
    logic [4:0]  bit_idx_s;
    axis_t       ax_s, ay_s;

    assign hc_s = {1'b0, bus.hcount};
    assign vc_s = {1'b0, bus.vcount};
    assign px_s = {1'b0, pos_x_q};
    assign py_s = {1'b0, pos_y_q};

    // Stage 0: box hit test at 11 bits so pos+size never wraps, plus row/column offsets.
    always_comb begin
        hit_s = (hc_s >= px_s) && (hc_s < (px_s + SPR_W11)) &&
                (vc_s >= py_s) && (vc_s < (py_s + SPR_H11));
        row_s = bus.vcount[3:0] - pos_y_q[3:0];
`ifdef SPRITE_MIRROR_EN
        if (mirror) begin
            col_s = COL_MAX - (bus.hcount[4:0] - pos_x_q[4:0]);
        end else begin
            col_s = bus.hcount[4:0] - pos_x_q[4:0];
        end
`else
        col_s = bus.hcount[4:0] - pos_x_q[4:0];
`endif
    end

    // Next-state for the ROM address and the stage-2 colour; ROM rows are stored leftmost-pixel-in-MSB.
    always_comb begin
        rom_addr_d = rom_addr_q;
        rgb_d      = 8'h00;
        bit_idx_s  = COL_MAX - col_q;
        if (hit_s) begin
            rom_addr_d = row_s;
        end else begin
            rom_addr_d = rom_addr_q;
        end
        if (!von_q) begin
            rgb_d = 8'h00;
        end else if (hit_q && bus.rom_data[bit_idx_s]) begin
            rgb_d = FG_COLOR;
        end else begin
            rgb_d = BG_COLOR;
        end
    end

    // Position/direction next-state; stage 0 of a tick cycle still sees the old position.
    always_comb begin
        ax_s = '{dir: dir_x_q, pos: pos_x_q};
        ay_s = '{dir: dir_y_q, pos: pos_y_q};
        if (bus.frame_tick && bus.move_en) begin
            ax_s = axis_next(pos_x_q, dir_x_q, X_MAX);
            ay_s = axis_next(pos_y_q, dir_y_q, Y_MAX);
        end else begin
            ax_s = '{dir: dir_x_q, pos: pos_x_q};
            ay_s = '{dir: dir_y_q, pos: pos_y_q};
        end
        pos_x_d = ax_s.pos;
        dir_x_d = ax_s.dir;
        pos_y_d = ay_s.pos;
        dir_y_d = ay_s.dir;
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q  <= 4'd0;
            hit_q       <= 1'b0;
            col_q       <= 5'd0;
            von_q       <= 1'b0;
            rgb_q       <= 8'h00;
            pix_valid_q <= 1'b0;
            pos_x_q     <= 10'd0;
            pos_y_q     <= 10'd0;
            dir_x_q     <= DIR_INC;
            dir_y_q     <= DIR_INC;
        end else begin
            rom_addr_q  <= rom_addr_d;
            hit_q       <= hit_s;
            col_q       <= col_s;
            von_q       <= bus.video_on;
            rgb_q       <= rgb_d;
            pix_valid_q <= von_q;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.rgb       = rgb_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
endmodule

// File: tb/tb_sprite_render.sv
// tb_sprite_render: table vectors, hand sequences and randomized traffic against a reference model.
module tb_sprite_render;
    localparam int X_LIM = 640 - 32;
    localparam int Y_LIM = 480 - 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_render_if bus ();
    sprite_render dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] rom_mem [16];
    assign bus.rom_data = rom_mem[bus.rom_addr];

    int         n_chk  = 0;
    int         n_fail = 0;
    int         n_ticks;
    logic [7:0] s1_rgb, out_rgb;
    logic       s1_v, out_v;
    logic [3:0] exp_addr;

    typedef struct {
        int         hc;
        int         vc;
        logic       von;
        logic [7:0] rgb;
        logic       v;
    } vec_t;
    vec_t vecs [10];

    // Bounce position after n enabled ticks: ramp 0..lim, dwell one tick at each end, period 2*(lim+1).
    function automatic int tri_pos(input int n, input int lim);
        int m;
        m = n % (2 * (lim + 1));
        return (m <= lim) ? m : (2 * lim + 1 - m);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One pixel cycle: drive at negedge, advance the model at posedge, compare at the next negedge.
    task automatic cycle(input int hc, input int vc, input logic von, input logic ft,
                         input logic me, input logic r);
        int          px, py, row, col;
        logic        hit;
        logic [7:0]  pix;
        logic [31:0] w;
        px = tri_pos(n_ticks, X_LIM);
        py = tri_pos(n_ticks, Y_LIM);
        bus.hcount     = 10'(hc);
        bus.vcount     = 10'(vc);
        bus.video_on   = von;
        bus.frame_tick = ft;
        bus.move_en    = me;
        rst            = r;
        hit = (hc >= px) && (hc < px + 32) && (vc >= py) && (vc < py + 16);
        row = vc - py;
        col = hc - px;
        pix = 8'h00;
        if (von && hit) begin
            w   = rom_mem[row];
            pix = w[31 - col] ? 8'hFF : 8'h00;
        end
        @(posedge clk);
        if (r) begin
            out_rgb = 8'h00; out_v = 1'b0; s1_rgb = 8'h00; s1_v = 1'b0;
            exp_addr = 4'd0; n_ticks = 0;
        end else begin
            out_rgb = s1_rgb; out_v = s1_v; s1_rgb = pix; s1_v = von;
            if (hit) exp_addr = 4'(row);
            if (ft && me) n_ticks++;
        end
        @(negedge clk);
        chk("rgb", 32'(bus.rgb), 32'(out_rgb));
        chk("pix_valid", 32'(bus.pix_valid), 32'(out_v));
        chk("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
        chk("pos_x", 32'(bus.pos_x), 32'(tri_pos(n_ticks, X_LIM)));
        chk("pos_y", 32'(bus.pos_y), 32'(tri_pos(n_ticks, Y_LIM)));
    endtask

    initial begin
        int hc, vc, px, py;
        rst = 1'b1;
        n_ticks = 0;
        s1_rgb = 8'h00; out_rgb = 8'h00; s1_v = 1'b0; out_v = 1'b0; exp_addr = 4'd0;
        bus.hcount = 10'd0; bus.vcount = 10'd0; bus.video_on = 1'b0;
        bus.frame_tick = 1'b0; bus.move_en = 1'b0;
        for (int i = 0; i < 16; i++) rom_mem[i] = 32'h7E0C1A02;
        @(negedge clk);

        // Reset for two cycles, then idle with no stimulus.
        cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_rgb", 32'(bus.rgb), 32'h0);
        chk("rst_valid", 32'(bus.pix_valid), 32'h0);
        chk("rst_addr", 32'(bus.rom_addr), 32'h0);
        chk("rst_pos", {6'd0, bus.pos_x, 6'd0, bus.pos_y}, 32'h0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_pos", {6'd0, bus.pos_x, 6'd0, bus.pos_y}, 32'h0);

        // Table vectors at pos (0,0) with every ROM row = 7E0C1A02.
        vecs[0] = '{0,  0,  1'b1, 8'h00, 1'b1};
        vecs[1] = '{1,  0,  1'b1, 8'hFF, 1'b1};
        vecs[2] = '{2,  0,  1'b1, 8'hFF, 1'b1};
        vecs[3] = '{7,  0,  1'b1, 8'h00, 1'b1};
        vecs[4] = '{32, 0,  1'b1, 8'h00, 1'b1};
        vecs[5] = '{0,  16, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{30, 3,  1'b1, 8'hFF, 1'b1};
        vecs[7] = '{31, 3,  1'b1, 8'h00, 1'b1};
        vecs[8] = '{5,  5,  1'b0, 8'h00, 1'b0};
        vecs[9] = '{1,  15, 1'b1, 8'hFF, 1'b1};
        for (int i = 0; i < 11; i++) begin
            if (i < 10) cycle(vecs[i].hc, vecs[i].vc, vecs[i].von, 1'b0, 1'b0, 1'b0);
            else        cycle(0, 100, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i >= 1) begin
                chk("vec_rgb", 32'(bus.rgb), 32'(vecs[i-1].rgb));
                chk("vec_valid", 32'(bus.pix_valid), 32'(vecs[i-1].v));
            end
        end

        // Ten enabled ticks, then five ignored ones.
        cycle(0, 300, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(0, 300, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("pos_after10", {6'd0, bus.pos_x, 6'd0, bus.pos_y}, {16'd10, 16'd10});
        for (int i = 0; i < 5; i++) cycle(0, 300, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pos_held", {6'd0, bus.pos_x, 6'd0, bus.pos_y}, {16'd10, 16'd10});

        // Long run from reset through both bounce edges.
        cycle(0, 300, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 610; t++) begin
            cycle(0, 300, 1'b0, 1'b1, 1'b1, 1'b0);
            if (t == 464) chk("y_edge", 32'(bus.pos_y), 32'd464);
            if (t == 465) chk("y_dwell", 32'(bus.pos_y), 32'd464);
            if (t == 466) chk("y_back", 32'(bus.pos_y), 32'd463);
            if (t == 608) chk("x_edge", 32'(bus.pos_x), 32'd608);
            if (t == 609) chk("x_dwell", 32'(bus.pos_x), 32'd608);
            if (t == 610) chk("x_back", 32'(bus.pos_x), 32'd607);
        end

        // Reset during active video with the sprite at (3,3).
        cycle(0, 300, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(0, 300, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(5, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_rgb", 32'(bus.rgb), 32'hFF);
        cycle(5, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_rgb", 32'(bus.rgb), 32'h0);
        chk("mid_rst_valid", 32'(bus.pix_valid), 32'h0);
        chk("mid_rst_pos", {6'd0, bus.pos_x, 6'd0, bus.pos_y}, 32'h0);
        cycle(5, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fill_rgb", 32'(bus.rgb), 32'h0);
        cycle(5, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("resume_rgb", 32'(bus.rgb), 32'hFF);
        chk("resume_valid", 32'(bus.pix_valid), 32'h1);

        // Randomized traffic around the sprite with a random ROM image.
        for (int i = 0; i < 16; i++) rom_mem[i] = $urandom;
        cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            px = tri_pos(n_ticks, X_LIM);
            py = tri_pos(n_ticks, Y_LIM);
            hc = int'($urandom_range(40, 0)) + px - 4;
            vc = int'($urandom_range(24, 0)) + py - 4;
            if (hc < 0) hc = 0;
            if (vc < 0) vc = 0;
            cycle(hc, vc, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
                  ($urandom_range(3, 0) != 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
